// File: rtl/bcd_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : bcd_ctrl_pkg
// Brief    : Shared state encoding, BCD constants and helpers for the
//            3-digit BCD counter controller.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package bcd_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [3:0]  DIGIT_MAX = 4'd9;
  localparam logic [11:0] BCD_ZERO  = 12'h000;

  // True when every nibble of a 3-digit value is a legal decimal digit.
  function automatic logic bcd_valid(input logic [11:0] v);
    return (v[3:0] <= DIGIT_MAX) && (v[7:4] <= DIGIT_MAX) && (v[11:8] <= DIGIT_MAX);
  endfunction

  // Value the digit chain will hold after one increment (999 wraps to 000).
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [11:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (c) begin
        if (r[i*4 +: 4] >= DIGIT_MAX) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
//------------------------------------------------------------------------------
// Module   : bcd_digit_cnt
// Brief    : One decimal digit (0..9) with increment enable, synchronous
//            load-zero and a carry-out flag marking the terminal digit value.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_digit_cnt
  import bcd_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_zero,
  input  logic       i_en,
  output logic [3:0] o_q,
  output logic       o_co
);

  logic [3:0] r_q;

  // Digit register: zero has priority over increment; 9 rolls over to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= 4'd0;
    end else if (i_zero) begin
      r_q <= 4'd0;
    end else if (i_en) begin
      r_q <= (r_q >= DIGIT_MAX) ? 4'd0 : (r_q + 4'd1);
    end
  end

  assign o_q  = r_q;
  // Carry means "the next increment of this digit ripples into the next one".
  assign o_co = (r_q >= DIGIT_MAX);

endmodule

`default_nettype wire

// File: rtl/bcd_counter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : bcd_counter_ctrl
// Brief    : 3-digit BCD counter with prescaled tick, terminal-count compare,
//            single-run / auto-reload modes and start/pause/clear control.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcd_counter_ctrl
  import bcd_ctrl_pkg::*;
#(
  parameter int DIV_W = 16
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic             reload,
  input  logic [DIV_W-1:0] div,
  input  logic [11:0]      target,
  output logic [11:0]      q,
  output logic             cout,
  output logic             hit,
  output logic             done,
  output logic             busy,
  output logic             cfg_err
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [DIV_W-1:0] r_presc;
  logic [DIV_W-1:0] w_presc_nxt;
  logic [DIV_W-1:0] r_div_l;
  logic [11:0]      r_target_l;
  logic             r_cout;
  logic             r_hit;
  logic             r_done;
  logic             r_busy;
  logic             r_cfg_err;

  logic             w_latch;
  logic             w_zero;
  logic             w_inc;
  logic             w_cout_nxt;
  logic             w_hit_nxt;
  logic             w_cfg_err_nxt;
  logic             w_tick;
  logic             w_target_ok;
  logic [11:0]      w_q;
  logic [11:0]      w_q_inc;
  logic [2:0]       w_co;
  logic [2:0]       w_en;

  assign w_tick      = (r_presc == (r_div_l - DIV_W'(1)));
  assign w_target_ok = bcd_valid(target);
  assign w_q_inc     = bcd_inc(w_q);

  // Command arbitration (clear > pause > start), prescaler and compare.
  always_comb begin
    w_state_nxt   = r_state;
    w_presc_nxt   = r_presc;
    w_latch       = 1'b0;
    w_zero        = 1'b0;
    w_inc         = 1'b0;
    w_cout_nxt    = 1'b0;
    w_hit_nxt     = 1'b0;
    w_cfg_err_nxt = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_presc_nxt = '0;
      w_zero      = 1'b1;
    end else if (pause) begin
      // Pause freezes q and the prescaler; it also masks start this cycle.
      if (r_state == ST_RUN) begin
        w_state_nxt = ST_PAUSE;
      end
    end else if (start && ((r_state == ST_IDLE) || (r_state == ST_DONE))) begin
      if (!w_target_ok) begin
        w_cfg_err_nxt = 1'b1;
      end else begin
        w_state_nxt = ST_RUN;
        w_latch     = 1'b1;
        w_zero      = 1'b1;
        w_presc_nxt = '0;
      end
    end else if (start && (r_state == ST_PAUSE)) begin
      w_state_nxt = ST_RUN;
    end else if (r_state == ST_RUN) begin
      if (w_tick) begin
        w_presc_nxt = '0;
        w_inc       = 1'b1;
        // Only a natural 999->000 step can produce zero here.
        w_cout_nxt  = (w_q_inc == BCD_ZERO);
        if (w_q_inc == r_target_l) begin
          w_hit_nxt = 1'b1;
          if (reload) begin
            w_zero = 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end else begin
        w_presc_nxt = r_presc + DIV_W'(1);
      end
    end
  end

  // State, prescaler, latched configuration and registered status outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      r_state    <= ST_IDLE;
      r_presc    <= '0;
      r_div_l    <= '0;
      r_target_l <= '0;
      r_cout     <= 1'b0;
      r_hit      <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_presc   <= w_presc_nxt;
      r_cout    <= w_cout_nxt;
      r_hit     <= w_hit_nxt;
      r_done    <= (w_state_nxt == ST_DONE);
      r_busy    <= (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
      r_cfg_err <= w_cfg_err_nxt;
      if (w_latch) begin
        // A divisor of zero behaves as one tick per cycle.
        r_div_l    <= (div == '0) ? DIV_W'(1) : div;
        r_target_l <= target;
      end
    end
  end

  // Ripple-enable chain: a digit advances when all lower digits are at 9.
  assign w_en[0] = w_inc;
  assign w_en[1] = w_inc & w_co[0];
  assign w_en[2] = w_inc & w_co[0] & w_co[1];

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_digit
      bcd_digit_cnt u_digit (
        .clk    (Clk),
        .rst_n  (Rst_n),
        .i_zero (w_zero),
        .i_en   (w_en[gi]),
        .o_q    (w_q[gi*4 +: 4]),
        .o_co   (w_co[gi])
      );
    end
  endgenerate

  assign q       = w_q;
  assign cout    = r_cout;
  assign hit     = r_hit;
  assign done    = r_done;
  assign busy    = r_busy;
  assign cfg_err = r_cfg_err;

endmodule

`default_nettype wire

// File: tb/tb_bcd_counter_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_bcd_counter_ctrl
// Brief    : Directed scoreboard bench for bcd_counter_ctrl. Expected pulse
//            events are queued by the stimulus; a negedge monitor pops them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_bcd_counter_ctrl;

  localparam int DIV_W = 16;

  logic             Clk    = 1'b0;
  logic             Rst_n  = 1'b0;
  logic             start  = 1'b0;
  logic             pause  = 1'b0;
  logic             clear  = 1'b0;
  logic             reload = 1'b0;
  logic [DIV_W-1:0] div    = '0;
  logic [11:0]      target = '0;
  logic [11:0]      q;
  logic             cout;
  logic             hit;
  logic             done;
  logic             busy;
  logic             cfg_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        hit;
    logic        cout;
    logic        cfg_err;
    logic [11:0] q;
    logic        done;
    logic        busy;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_act;
  ev_t mon_exp;

  bcd_counter_ctrl #(.DIV_W(DIV_W)) dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .start   (start),
    .pause   (pause),
    .clear   (clear),
    .reload  (reload),
    .div     (div),
    .target  (target),
    .q       (q),
    .cout    (cout),
    .hit     (hit),
    .done    (done),
    .busy    (busy),
    .cfg_err (cfg_err)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  function automatic logic [11:0] bcd(input int k);
    return {4'(k / 100), 4'((k / 10) % 10), 4'(k % 10)};
  endfunction

  task automatic expect_ev(input logic h, input logic c, input logic e,
                           input logic [11:0] qv, input logic d, input logic b);
    ev_t ev;
    ev.hit = h; ev.cout = c; ev.cfg_err = e; ev.q = qv; ev.done = d; ev.busy = b;
    exp_q.push_back(ev);
  endtask

  // Monitor: any pulse output is an event that must match the queue head.
  always @(negedge Clk) begin
    if (hit || cout || cfg_err) begin
      mon_act = {hit, cout, cfg_err, q, done, busy};
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_event: got %0h expected none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        check("event", 32'(mon_act), 32'(mon_exp));
      end
    end
  end

  // Time-limit guard.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    Rst_n = 1'b0;
    step(2);
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pulses", {hit, cout, cfg_err}, 0);

    // Single-run; start issued on the first edge with reset released
    div = 3; target = 12'h012; reload = 1'b0;
    Rst_n = 1'b1; start = 1'b1;
    expect_ev(1'b1, 1'b0, 1'b0, 12'h012, 1'b1, 1'b0);
    step(1); start = 1'b0;
    check("first_cmd_busy", busy, 1);
    check("first_cmd_q", q, 0);
    for (int k = 1; k <= 12; k++) begin
      step(3);
      check("single_q", q, bcd(k));
    end
    check("single_done", done, 1);
    check("single_busy", busy, 0);
    step(5);
    check("single_hold_q", q, 12'h012);
    check("single_hold_done", done, 1);

    // Bad target rejected from DONE: q and state untouched
    target = 12'h0A5; start = 1'b1;
    expect_ev(1'b0, 1'b0, 1'b1, 12'h012, 1'b1, 1'b0);
    step(1); start = 1'b0;
    check("badcfg_done_q", q, 12'h012);
    check("badcfg_done_done", done, 1);

    clear = 1'b1; step(1); clear = 1'b0;
    check("clear_q", q, 0);
    check("clear_done", done, 0);
    check("clear_busy", busy, 0);

    // Bad target rejected from IDLE
    start = 1'b1;
    expect_ev(1'b0, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0);
    step(1); start = 1'b0;
    check("badcfg_idle_busy", busy, 0);
    check("badcfg_idle_q", q, 0);
    step(1);
    check("badcfg_pulse_end", cfg_err, 0);

    // Auto-reload, full 1000-tick period
    div = 1; target = 12'h000; reload = 1'b1; start = 1'b1;
    expect_ev(1'b1, 1'b1, 1'b0, 12'h000, 1'b0, 1'b1);
    step(1); start = 1'b0;
    check("full_q0", q, 0);
    step(1);   check("full_q1", q, bcd(1));
    step(498); check("full_q499", q, bcd(499));
    step(500); check("full_q999", q, bcd(999));
    check("full_busy999", busy, 1);
    step(1);   check("full_wrap_q", q, 0);
    check("full_wrap_busy", busy, 1);
    step(1);   check("full_after_q", q, bcd(1));

    clear = 1'b1; step(1); clear = 1'b0;
    check("clear2_q", q, 0);

    // Auto-reload at target 5, then reload dropped live -> single-run stop
    div = 2; target = 12'h005; reload = 1'b1; start = 1'b1;
    expect_ev(1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 1'b0, 12'h005, 1'b1, 1'b0);
    step(1); start = 1'b0;
    step(10);
    check("reload_q", q, 0);
    check("reload_busy", busy, 1);
    reload = 1'b0;
    step(10);
    check("reload_off_q", q, 12'h005);
    check("reload_off_done", done, 1);

    // Pause mid-prescale at 057 and resume
    div = 4; target = 12'h099; reload = 1'b0; start = 1'b1;
    step(1); start = 1'b0;
    step(228);
    check("pause_pre_q", q, 12'h057);
    step(1);
    pause = 1'b1; step(1); pause = 1'b0;
    check("pause_q", q, 12'h057);
    check("pause_busy", busy, 1);
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("pause_hold_q", q, 12'h057);
    end
    start = 1'b1; step(1); start = 1'b0;
    check("resume_q", q, 12'h057);
    step(2);
    check("resume_q2", q, 12'h057);
    step(1);
    check("resume_tick_q", q, 12'h058);

    // Pause colliding with a tick suppresses the increment
    step(3);
    pause = 1'b1; step(1); pause = 1'b0;
    check("pause_tick_q", q, 12'h058);
    start = 1'b1; step(1); start = 1'b0;
    check("resume2_q", q, 12'h058);
    step(1);
    check("resume2_tick_q", q, 12'h059);

    // clear + pause + start together: clear wins
    clear = 1'b1; pause = 1'b1; start = 1'b1;
    step(1);
    clear = 1'b0; pause = 1'b0; start = 1'b0;
    check("prio_q", q, 0);
    check("prio_busy", busy, 0);
    check("prio_done", done, 0);
    step(1);
    check("prio_idle_busy", busy, 0);

    // Reset mid-RUN at 042
    div = 1; target = 12'h099; reload = 1'b0; start = 1'b1;
    step(1); start = 1'b0;
    step(42);
    check("prerst_q", q, 12'h042);
    Rst_n = 1'b0; step(1); Rst_n = 1'b1;
    check("midrst_q", q, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    step(2);
    check("postrst_q", q, 0);

    step(2);
    check("events_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_counter_ctrl.md
BCD_COUNTER_CTRL -- requirements
Module: bcd_counter_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the tick prescaler divisor.
REQ-002 SHALL have port Clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port Rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port start  input  1  start/resume command, level-sampled each cycle.
REQ-005 SHALL have port pause  input  1  pause command.
REQ-006 SHALL have port clear  input  1  abort and zero command.
REQ-007 SHALL have port reload  input  1  mode select: 1 = auto-reload, 0 = single-run.
REQ-008 SHALL have port div  input  DIV_W  clock cycles per count tick; 0 is treated as 1.
REQ-009 SHALL have port target  input  12  3-digit BCD terminal count {hundreds,tens,ones}.
REQ-010 SHALL have port q  output  12  current 3-digit BCD count.
REQ-011 SHALL have port cout  output  1  one-cycle pulse on the natural 999->000 wrap.
REQ-012 SHALL have port hit  output  1  one-cycle pulse when the count reaches target.
REQ-013 SHALL have port done  output  1  level, high while in DONE.
REQ-014 SHALL have port busy  output  1  level, high in RUN or PAUSE.
REQ-015 SHALL have port cfg_err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-017 SHALL resolve simultaneous commands with priority clear > pause > start.
REQ-018 On clear, from any state: next state IDLE; q, prescaler, hit, cout and done go to 0.
REQ-019 On start in IDLE or DONE: latch div and target, zero q and prescaler, enter RUN.
REQ-020 SHALL ignore start in RUN.
REQ-021 On start in PAUSE: resume RUN with prescaler and q intact, without relatching.
REQ-022 SHALL reject start, pulse cfg_err and stay in state if any target nibble > 9.
REQ-023 On pause in RUN: enter PAUSE, holding q and the prescaler.
REQ-024 SHALL ignore pause outside RUN.
REQ-025 Prescaler: in RUN, count 0..div_l-1; at div_l-1 generate a tick and return to 0.
REQ-026 On the clock edge of a tick, q SHALL increment by 1 in BCD, with decimal carry per digit.
REQ-027 With div_l = 1, q SHALL increment every RUN cycle.
REQ-028 If a tick takes q from 999 to 000, cout SHALL be 1 in the following cycle.
REQ-029 Target match: when the incremented value equals target_l, hit SHALL be 1 in the following cycle.
REQ-030 In single-run mode, q SHALL hold target_l and the state SHALL go to DONE.
REQ-031 In auto-reload mode, q SHALL load 000 instead, stay in RUN, and not assert cout (unless target_l = 000).
REQ-032 target_l = 000 SHALL mean a full 1000-tick period: the 999->000 tick asserts both hit and cout.
REQ-033 The reload input SHALL be sampled live at each match.
REQ-034 If pause or clear coincides with a tick, the command SHALL win and no increment or pulse occurs.
REQ-035 done = (state==DONE); busy = (state==RUN or PAUSE); all outputs SHALL be registered.

Reset
REQ-036 While Rst_n is low at a rising Clk: state IDLE; q, cout, hit, done, busy, cfg_err, prescaler, div_l and target_l all 0.
REQ-037 Reset SHALL override all commands, including mid-RUN.
REQ-038 The first command SHALL be accepted on the first edge with Rst_n high.

Structure
REQ-039 State encoding and BCD digit constants (DIGIT_MAX = 4'd9) SHALL live in shared package bcd_ctrl_pkg.
REQ-040 SHALL use one sub-module, bcd_digit_cnt, a 4-bit BCD digit with en, load-zero, carry-out.
REQ-041 SHALL chain three bcd_digit_cnt instances for q.
REQ-042 The controller FSM, prescaler and compare SHALL live in bcd_counter_ctrl.

Verification
REQ-043 Reset mid-RUN: Rst_n=0 for 1 cycle with q=0x042 -> next cycle q=0x000, state IDLE, busy=0.
REQ-044 Single-run: div=3, target=0x012, reload=0, start pulse -> q steps every 3 cycles; hit pulse and done=1 at q=0x012; q holds.
REQ-045 Auto-reload, full period: div=1, target=0x000, reload=1 -> q 000..999; cout and hit pulse together at wrap; busy stays 1.
REQ-046 Pause/resume: pause at q=0x057 mid-prescale, hold 10 cycles, start -> q=0x057 throughout; the next tick lands exactly the remaining prescale cycles later.
REQ-047 Priority/collision: clear+pause+start in one cycle during RUN -> IDLE, q=0; pause on a tick cycle -> no increment.
REQ-048 Bad config: target=0x0A5, start -> cfg_err pulse, state IDLE, q unchanged.
